// File: rtl/mem_stage.sv
// Pipeline memory-access stage: req/ack data-memory loads/stores, lane steering, bus timeout.
// Optional alignment-exception logic is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  mem_op,
  input  logic [31:0] ex_res,
  input  logic [31:0] store_data,
  input  logic [4:0]  reg_addr,
  input  logic        reg_we,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg_addr,
  output logic        wb_we,
  output logic        dm_req,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic [31:0] exc_badvaddr,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on any rising edge where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic        wr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt_q;

  logic        is_load, is_store, misalign, accept, drain, timeout, done, load_out;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in;
  logic [31:0] data_nx, badv_nx;
  logic [4:0]  reg_nx;
  logic        we_nx, adel_nx, ades_nx, bus_nx;

  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'd0, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'd0, h};
      default: load_extract = d;
    endcase
  endfunction

  assign is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
  assign is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && ex_res[0])
                 || (((mem_op == OP_LW) || (mem_op == OP_SW)) && (ex_res[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    wstrb_in = 4'b0000;
    wdata_in = store_data;
    case (mem_op)
      OP_SB: begin
        wstrb_in = 4'b0001 << ex_res[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      OP_SH: begin
        wstrb_in = ex_res[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data[15:0]}};
      end
      OP_SW:   wstrb_in = 4'b1111;
      default: wstrb_in = 4'b0000;
    endcase
  end

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign timeout  = (state == REQ) && !dm_ack && (cnt_q == TO_LAST);
  assign done     = (state == REQ) && (dm_ack || timeout);
  // Items that bypass memory (ALU ops, alignment faults) land in the output register directly.
  assign load_out = accept && (!(is_load || is_store) || misalign);

  // Request outputs derive from the state register so reset kills dm_req without a clock.
  assign dm_req    = (state == REQ);
  assign dm_wr     = dm_req && wr_q;
  assign dm_wstrb  = dm_req ? wstrb_q : 4'b0000;
  assign dm_wdata  = wdata_q;
  assign dm_addr   = {addr_q[31:2], 2'b00};
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && (is_load || is_store) && !misalign) state_nx = REQ;
      REQ:  if (done) state_nx = out_ready ? IDLE : HOLD;
      HOLD: if (drain) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    data_nx = ex_res;
    reg_nx  = reg_addr;
    we_nx   = reg_we;
    adel_nx = 1'b0;
    ades_nx = 1'b0;
    bus_nx  = 1'b0;
    badv_nx = 32'd0;
    if (state == REQ) begin
      reg_nx  = rd_q;
      data_nx = addr_q;
      we_nx   = 1'b0;
      if (timeout) begin
        bus_nx  = 1'b1;
        badv_nx = addr_q;
      end else if (!wr_q) begin
        data_nx = load_extract(op_q, addr_q[1:0], dm_rdata);
        we_nx   = we_q;
      end
    end else if (misalign) begin
      we_nx   = 1'b0;
      adel_nx = is_load;
      ades_nx = is_store;
      badv_nx = ex_res;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= 4'd0;
      addr_q  <= 32'd0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'd0;
      cnt_q   <= 16'd0;
    end else begin
      if (accept && (is_load || is_store) && !misalign) begin
        op_q    <= mem_op;
        addr_q  <= ex_res;
        rd_q    <= reg_addr;
        we_q    <= reg_we;
        wr_q    <= is_store;
        wstrb_q <= wstrb_in;
        wdata_q <= wdata_in;
      end
      cnt_q <= (state == REQ) ? cnt_q + 16'd1 : 16'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      wb_data      <= 32'd0;
      wb_reg_addr  <= 5'd0;
      wb_we        <= 1'b0;
      exc_adel     <= 1'b0;
      exc_ades     <= 1'b0;
      exc_bus      <= 1'b0;
      exc_badvaddr <= 32'd0;
    end else if (load_out || done) begin
      out_valid    <= 1'b1;
      wb_data      <= data_nx;
      wb_reg_addr  <= reg_nx;
      wb_we        <= we_nx;
      exc_adel     <= adel_nx;
      exc_ades     <= ades_nx;
      exc_bus      <= bus_nx;
      exc_badvaddr <= badv_nx;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table plus hand-written timeout, backpressure,
// spurious-ack and reset sequences; a scoreboard checks every write-back item in order.
module tb_mem_stage;

  localparam int W = 41;  // {wb_data, wb_reg_addr, wb_we, exc_adel, exc_ades, exc_bus}

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] ex_res = 32'd0, store_data = 32'd0;
  logic [4:0]  reg_addr = 5'd0;
  logic        reg_we = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg_addr;
  logic        wb_we;
  logic        dm_req, dm_wr;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'd0;
  logic        exc_adel, exc_ades, exc_bus;
  logic [31:0] exc_badvaddr;
  logic [1:0]  dbg_state;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .ex_res(ex_res), .store_data(store_data), .reg_addr(reg_addr),
    .reg_we(reg_we), .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data),
    .wb_reg_addr(wb_reg_addr), .wb_we(wb_we), .dm_req(dm_req), .dm_wr(dm_wr),
    .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
    .exc_badvaddr(exc_badvaddr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got item 0x%08h with no expected entry", wb_data);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_reg", {27'd0, wb_reg_addr}, {27'd0, sb_e[8:4]});
        chk("sb_we", {31'd0, wb_we}, {31'd0, sb_e[3]});
        chk("sb_exc", {29'd0, exc_adel, exc_ades, exc_bus}, {29'd0, sb_e[2:0]});
        if (sb_e[3]) chk("sb_data", wb_data, sb_e[40:9]);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        we;
    int          delay;      // dm_ack arrives on this request cycle (0 = first)
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_wr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_daddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    logic        exp_we;
    logic        exp_adel;
    logic        exp_ades;
  } vec_t;

  vec_t vecs[10];

  // ---------------- driver tasks ----------------
  task automatic run_vec(input vec_t v);
    bit got;
    @(posedge clk); #1;
    chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; mem_op = v.op; ex_res = v.addr; store_data = v.sdata;
    reg_addr = v.rd; reg_we = v.we; out_ready = 1'b1;
    exp_q.push_back({v.exp_wb, v.rd, v.exp_we, v.exp_adel, v.exp_ades, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = 4'd0;
    if (v.exp_req) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk);
        chk("dm_req", {31'd0, dm_req}, 32'd1);
        chk("dm_addr", dm_addr, v.exp_daddr);
        chk("dm_wr", {31'd0, dm_wr}, {31'd0, v.exp_wr});
        chk("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, v.exp_wstrb});
        if (v.exp_wr) chk("dm_wdata", dm_wdata, v.exp_wdata);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (k == v.delay) begin
          dm_ack = 1'b1; dm_rdata = v.rdata; got = 1'b1;
        end
        @(posedge clk); #1;
        dm_ack = 1'b0; dm_rdata = $urandom;
      end
      if (!got) begin
        n_checks++; n_fail++;
        $display("FAIL ack_bound: request never acknowledged within 8 cycles");
      end
    end
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("dm_req_after", {31'd0, dm_req}, 32'd0);
    chk("wb_we", {31'd0, wb_we}, {31'd0, v.exp_we});
    chk("wb_reg_addr", {27'd0, wb_reg_addr}, {27'd0, v.rd});
    if (v.exp_we) chk("wb_data", wb_data, v.exp_wb);
    chk("exc_adel", {31'd0, exc_adel}, {31'd0, v.exp_adel});
    chk("exc_ades", {31'd0, exc_ades}, {31'd0, v.exp_ades});
    if (v.exp_adel || v.exp_ades) chk("exc_badvaddr", exc_badvaddr, v.addr);
  endtask

  // ---------------- test ----------------
  initial begin
    //            op     addr          sdata         rd  we dly rdata         req wr strb     daddr         wdata         wb            we adel ades
    vecs[0] = '{4'd0,  32'h0000_1234, 32'h0,        5'd5, 1, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0000_1234, 1, 0, 0};
    vecs[1] = '{4'd1,  32'h0000_0103, 32'h0,        5'd7, 1, 2, 32'h80FF_0000, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 1, 0, 0};
    vecs[2] = '{4'd2,  32'h0000_0103, 32'h0,        5'd8, 1, 2, 32'h80FF_0000, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'h0000_0080, 1, 0, 0};
    vecs[3] = '{4'd7,  32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 1, 0, 32'h0,        1, 1, 4'b1100, 32'h0000_0200, 32'hBEEF_BEEF, 32'h0,        0, 0, 0};
    vecs[4] = '{4'd3,  32'h0000_0102, 32'h0,        5'd9, 1, 1, 32'h8001_1234, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,        32'hFFFF_8001, 1, 0, 0};
    vecs[5] = '{4'd4,  32'h0000_0100, 32'h0,        5'd10, 1, 0, 32'h8001_F234, 1, 0, 4'b0000, 32'h0000_0100, 32'h0,       32'h0000_F234, 1, 0, 0};
    vecs[6] = '{4'd6,  32'h0000_0011, 32'h0000_00A5, 5'd4, 1, 1, 32'h0,        1, 1, 4'b0010, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,        0, 0, 0};
    vecs[7] = '{4'd8,  32'h0000_0020, 32'h1234_5678, 5'd4, 1, 0, 32'h0,        1, 1, 4'b1111, 32'h0000_0020, 32'h1234_5678, 32'h0,        0, 0, 0};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[8] = '{4'd5,  32'h0000_0301, 32'h0,        5'd11, 1, 0, 32'hCAFE_F00D, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        0, 1, 0};
`else
    vecs[8] = '{4'd5,  32'h0000_0301, 32'h0,        5'd11, 1, 1, 32'hCAFE_F00D, 1, 0, 4'b0000, 32'h0000_0300, 32'h0,       32'hCAFE_F00D, 1, 0, 0};
`endif
    vecs[9] = '{4'd12, 32'h0000_ABCD, 32'h0,        5'd12, 1, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0000_ABCD, 1, 0, 0};

    // reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_dm_wr", {31'd0, dm_wr}, 32'd0);
    chk("rst_dm_wstrb", {28'd0, dm_wstrb}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_reg", {27'd0, wb_reg_addr}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_exc", {29'd0, exc_adel, exc_ades, exc_bus}, 32'd0);
    chk("rst_badvaddr", exc_badvaddr, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // bus timeout: TIMEOUT_CYCLES=4, no ack
    @(posedge clk); #1;
    in_valid = 1'b1; mem_op = 4'd5; ex_res = 32'h0000_0400; reg_addr = 5'd9; reg_we = 1'b1;
    exp_q.push_back({32'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_dm_req_high", {31'd0, dm_req}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_dm_req_low", {31'd0, dm_req}, 32'd0);
    chk("to_out_valid", {31'd0, out_valid}, 32'd1);
    chk("to_exc_bus", {31'd0, exc_bus}, 32'd1);
    chk("to_wb_we", {31'd0, wb_we}, 32'd0);
    chk("to_badvaddr", exc_badvaddr, 32'h0000_0400);

    // back-to-back ALU ops with write-back stalled for two cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; mem_op = 4'd0; ex_res = 32'h0000_0011; reg_addr = 5'd1; reg_we = 1'b1;
    exp_q.push_back({32'h0000_0011, 5'd1, 1'b1, 3'b000});
    @(posedge clk); #1;
    ex_res = 32'h0000_0022; reg_addr = 5'd2;
    exp_q.push_back({32'h0000_0022, 5'd2, 1'b1, 3'b000});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", wb_data, 32'h0000_0011);
      chk("bp_hold_reg", {27'd0, wb_reg_addr}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_drain", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_second_data", wb_data, 32'h0000_0022);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // dm_ack with no request outstanding is ignored
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_valid", {31'd0, out_valid}, 32'd0);
    chk("stray_ack_state", {30'd0, dbg_state}, 32'd0);

    // reset while a request is outstanding
    @(posedge clk); #1;
    in_valid = 1'b1; mem_op = 4'd5; ex_res = 32'h0000_0500; reg_addr = 5'd6; reg_we = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = 4'd0;
    @(negedge clk);
    chk("mid_dm_req", {31'd0, dm_req}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // recovery after reset
    run_vec(vecs[0]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
